// File: rtl/bf_data_unit.sv
// Tape data-path controller: runs cell add/sub, pointer moves and byte I/O
// against a combinational-read data memory, caching the current cell locally.
module bf_data_unit #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          op_valid,
  output logic          op_ready,
  input  logic [2:0]    op_code,
  input  logic [DW-1:0] op_arg,
  output logic [AW-1:0] mem_addr,
  output logic          mem_read,
  output logic          mem_write,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          cell_zero,
  output logic [AW-1:0] ptr
);

  localparam logic [2:0] OP_ADD   = 3'b001;
  localparam logic [2:0] OP_SUB   = 3'b010;
  localparam logic [2:0] OP_RIGHT = 3'b011;
  localparam logic [2:0] OP_LEFT  = 3'b100;
  localparam logic [2:0] OP_OUT   = 3'b101;
  localparam logic [2:0] OP_IN    = 3'b110;

  typedef enum logic [1:0] {
    LOAD     = 2'd0,
    IDLE     = 2'd1,
    WAIT_OUT = 2'd2,
    WAIT_IN  = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic [AW-1:0] r_ptr;
  logic [AW-1:0] w_next_ptr;
  logic [AW-1:0] w_step;
  logic [DW-1:0] r_cell;
  logic [DW-1:0] w_next_cell;

  assign w_step = op_arg[AW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= LOAD;
      r_ptr   <= '0;
      r_cell  <= '0;
    end else begin
      r_state <= w_next_state;
      r_ptr   <= w_next_ptr;
      r_cell  <= w_next_cell;
    end
  end

  // Writes go out in the same cycle the op is accepted, so the cached cell
  // and memory always agree at the next edge without a re-read.
  always_comb begin
    w_next_state = r_state;
    w_next_ptr   = r_ptr;
    w_next_cell  = r_cell;
    op_ready     = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_wdata    = r_cell;
    out_valid    = 1'b0;
    in_ready     = 1'b0;
    unique case (r_state)
      LOAD: begin
        mem_read     = 1'b1;
        w_next_cell  = mem_rdata;
        w_next_state = IDLE;
      end
      IDLE: begin
        op_ready = 1'b1;
        if (op_valid) begin
          case (op_code)
            OP_ADD: begin
              mem_write   = 1'b1;
              mem_wdata   = r_cell + op_arg;
              w_next_cell = r_cell + op_arg;
            end
            OP_SUB: begin
              mem_write   = 1'b1;
              mem_wdata   = r_cell - op_arg;
              w_next_cell = r_cell - op_arg;
            end
            OP_RIGHT: begin
              w_next_ptr   = r_ptr + w_step;
              w_next_state = LOAD;
            end
            OP_LEFT: begin
              w_next_ptr   = r_ptr - w_step;
              w_next_state = LOAD;
            end
            OP_OUT:  w_next_state = WAIT_OUT;
            OP_IN:   w_next_state = WAIT_IN;
            default: w_next_state = IDLE;
          endcase
        end
      end
      WAIT_OUT: begin
        out_valid = 1'b1;
        if (out_ready) w_next_state = IDLE;
      end
      WAIT_IN: begin
        in_ready = 1'b1;
        if (in_valid) begin
          mem_write    = 1'b1;
          mem_wdata    = in_data;
          w_next_cell  = in_data;
          w_next_state = IDLE;
        end
      end
      default: w_next_state = LOAD;
    endcase
  end

  assign mem_addr  = r_ptr;
  assign ptr       = r_ptr;
  assign out_data  = r_cell;
  assign cell_zero = (r_cell == '0);

endmodule

// File: tb/tb_bf_data_unit.sv
// Self-checking bench for bf_data_unit: a tape+pointer reference model and a
// behavioural data memory, driven by directed scenarios and random op streams.
module tb_bf_data_unit;

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_ADD   = 3'b001;
  localparam logic [2:0] OP_SUB   = 3'b010;
  localparam logic [2:0] OP_RIGHT = 3'b011;
  localparam logic [2:0] OP_LEFT  = 3'b100;
  localparam logic [2:0] OP_OUT   = 3'b101;
  localparam logic [2:0] OP_IN    = 3'b110;

  logic       clk;
  logic       rst_n;
  logic       op_valid;
  logic       op_ready;
  logic [2:0] op_code;
  logic [7:0] op_arg;
  logic [7:0] mem_addr;
  logic       mem_read;
  logic       mem_write;
  logic [7:0] mem_wdata;
  wire  [7:0] mem_rdata;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       cell_zero;
  logic [7:0] ptr;

  logic [7:0] dm [256];
  logic [7:0] refTape [256];
  logic [7:0] refPtr;
  int nCompared;
  int nMismatched;

  bf_data_unit #(.AW(8), .DW(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code), .op_arg(op_arg),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .cell_zero(cell_zero), .ptr(ptr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory: combinational read, write on the rising edge.
  assign mem_rdata = mem_read ? dm[mem_addr] : 8'bz;
  always @(posedge clk) if (mem_write) dm[mem_addr] <= mem_wdata;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  // Runs one accepted op and checks every cycle until the unit is ready again.
  task automatic exec_op(input logic [2:0] code, input logic [7:0] arg,
                         input int stall, input logic [7:0] inByte);
    logic [7:0] cur;
    logic [7:0] expW;
    logic       isWrite;
    cur     = refTape[refPtr];
    isWrite = (code == OP_ADD) || (code == OP_SUB);
    expW    = (code == OP_ADD) ? cur + arg : (code == OP_SUB) ? cur - arg : cur;
    op_valid = 1'b1; op_code = code; op_arg = arg;
    #1;
    nCompared++;
    if (op_ready !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL accept_ready op=%0d: got %b expected 1", code, op_ready);
    end
    nCompared++;
    if (isWrite) begin
      if ({mem_write, mem_addr, mem_wdata} !== {1'b1, refPtr, expW}) begin
        nMismatched++;
        $display("[TB] FAIL op_write op=%0d: got we=%b addr=%h data=%h expected we=1 addr=%h data=%h",
                 code, mem_write, mem_addr, mem_wdata, refPtr, expW);
      end
    end else if (mem_write !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL op_nowrite op=%0d: got we=%b expected 0", code, mem_write);
    end
    @(posedge clk); @(negedge clk);
    op_valid = 1'b0; op_code = 3'($urandom); op_arg = 8'($urandom);
    if (isWrite) refTape[refPtr] = expW;
    if (code == OP_RIGHT) refPtr = refPtr + arg;
    if (code == OP_LEFT)  refPtr = refPtr - arg;
    if (code == OP_RIGHT || code == OP_LEFT) begin
      #1;
      nCompared++;
      if ({op_ready, mem_read, mem_write, ptr} !== {1'b0, 1'b1, 1'b0, refPtr}) begin
        nMismatched++;
        $display("[TB] FAIL load_cycle: got rdy=%b rd=%b we=%b ptr=%h expected rdy=0 rd=1 we=0 ptr=%h",
                 op_ready, mem_read, mem_write, ptr, refPtr);
      end
      @(posedge clk); @(negedge clk);
    end else if (code == OP_OUT) begin
      for (int i = 0; i <= stall; i++) begin
        out_ready = (i == stall);
        #1;
        nCompared++;
        if ({out_valid, op_ready, mem_write, out_data} !== {1'b1, 1'b0, 1'b0, cur}) begin
          nMismatched++;
          $display("[TB] FAIL wait_out cyc=%0d: got vld=%b rdy=%b we=%b data=%h expected vld=1 rdy=0 we=0 data=%h",
                   i, out_valid, op_ready, mem_write, out_data, cur);
        end
        @(posedge clk); @(negedge clk);
      end
      out_ready = 1'b0;
    end else if (code == OP_IN) begin
      for (int i = 0; i <= stall; i++) begin
        in_valid = (i == stall);
        in_data  = (i == stall) ? inByte : 8'($urandom);
        #1;
        nCompared++;
        if ({in_ready, op_ready} !== 2'b10) begin
          nMismatched++;
          $display("[TB] FAIL wait_in cyc=%0d: got in_rdy=%b op_rdy=%b expected in_rdy=1 op_rdy=0",
                   i, in_ready, op_ready);
        end
        nCompared++;
        if ((i == stall) ? ({mem_write, mem_addr, mem_wdata} !== {1'b1, refPtr, inByte})
                         : (mem_write !== 1'b0)) begin
          nMismatched++;
          $display("[TB] FAIL in_write cyc=%0d: got we=%b addr=%h data=%h expected we=%b addr=%h data=%h",
                   i, mem_write, mem_addr, mem_wdata, (i == stall), refPtr, inByte);
        end
        @(posedge clk); @(negedge clk);
      end
      in_valid = 1'b0;
      refTape[refPtr] = inByte;
    end
    #1;
    nCompared++;
    if ({op_ready, cell_zero, ptr, out_valid, in_ready} !==
        {1'b1, refTape[refPtr] == 8'h00, refPtr, 1'b0, 1'b0}) begin
      nMismatched++;
      $display("[TB] FAIL after_op op=%0d: got rdy=%b zero=%b ptr=%h ov=%b ir=%b expected rdy=1 zero=%b ptr=%h ov=0 ir=0",
               code, op_ready, cell_zero, ptr, out_valid, in_ready, refTape[refPtr] == 8'h00, refPtr);
    end
  endtask

  task automatic test_reset;
    for (int a = 0; a < 256; a++) begin
      dm[a] = 8'h00;
      refTape[a] = 8'h00;
    end
    dm[3] = 8'h10;   refTape[3] = 8'h10;
    dm[255] = 8'hA5; refTape[255] = 8'hA5;
    refPtr = 8'h00;
    rst_n = 1'b0; op_valid = 1'b0; op_code = OP_NOP; op_arg = 8'h00;
    out_ready = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    @(negedge clk); #1;
    nCompared++;
    if ({op_ready, mem_write, out_valid, in_ready, cell_zero, ptr} !== {5'b00001, 8'h00}) begin
      nMismatched++;
      $display("[TB] FAIL reset_outputs: got rdy=%b we=%b ov=%b ir=%b zero=%b ptr=%h expected 0 0 0 0 1 00",
               op_ready, mem_write, out_valid, in_ready, cell_zero, ptr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    nCompared++;
    if ({mem_read, op_ready} !== 2'b10) begin
      nMismatched++;
      $display("[TB] FAIL reset_load: got rd=%b rdy=%b expected rd=1 rdy=0", mem_read, op_ready);
    end
    @(posedge clk); @(negedge clk); #1;
    nCompared++;
    if ({op_ready, cell_zero, ptr} !== {2'b11, 8'h00}) begin
      nMismatched++;
      $display("[TB] FAIL reset_idle: got rdy=%b zero=%b ptr=%h expected rdy=1 zero=1 ptr=00",
               op_ready, cell_zero, ptr);
    end
  endtask

  task automatic test_add_sub_chain;
    exec_op(OP_ADD, 8'd5, 0, 8'h00);
    exec_op(OP_ADD, 8'd3, 0, 8'h00);
    exec_op(OP_SUB, 8'd1, 0, 8'h00);
  endtask

  task automatic test_wrap_left;
    exec_op(OP_SUB, 8'd7, 0, 8'h00);
    exec_op(OP_SUB, 8'd1, 0, 8'h00);
    exec_op(OP_LEFT, 8'd1, 0, 8'h00);
  endtask

  task automatic test_move_then_add;
    exec_op(OP_RIGHT, 8'd4, 0, 8'h00);
    exec_op(OP_ADD, 8'd2, 0, 8'h00);
    exec_op(OP_RIGHT, 8'd0, 0, 8'h00);
  endtask

  task automatic test_out_stall;
    exec_op(OP_OUT, 8'h00, 4, 8'h00);
    exec_op(OP_OUT, 8'h00, 0, 8'h00);
  endtask

  task automatic test_in;
    exec_op(OP_IN, 8'h00, 3, 8'h00);
    exec_op(OP_NOP, 8'h33, 0, 8'h00);
    exec_op(3'b111, 8'h44, 0, 8'h00);
  endtask

  task automatic test_reset_mid_in;
    logic [7:0] savedPtr;
    exec_op(OP_ADD, 8'h21, 0, 8'h00);
    savedPtr = refPtr;
    op_valid = 1'b1; op_code = OP_IN;
    @(posedge clk); @(negedge clk);
    op_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b1; in_data = 8'h5A;
    #1;
    nCompared++;
    if ({op_ready, mem_write, out_valid, in_ready, cell_zero, ptr} !== {5'b00001, 8'h00}) begin
      nMismatched++;
      $display("[TB] FAIL reset_mid_in: got rdy=%b we=%b ov=%b ir=%b zero=%b ptr=%h expected 0 0 0 0 1 00",
               op_ready, mem_write, out_valid, in_ready, cell_zero, ptr);
    end
    @(posedge clk); @(negedge clk);
    nCompared++;
    if (dm[savedPtr] !== refTape[savedPtr]) begin
      nMismatched++;
      $display("[TB] FAIL reset_no_write: got dm=%h expected %h", dm[savedPtr], refTape[savedPtr]);
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
    refPtr = 8'h00;
    @(posedge clk); @(negedge clk); #1;
    nCompared++;
    if ({op_ready, cell_zero, ptr} !== {1'b1, refTape[0] == 8'h00, 8'h00}) begin
      nMismatched++;
      $display("[TB] FAIL reset_recover: got rdy=%b zero=%b ptr=%h expected rdy=1 zero=%b ptr=00",
               op_ready, cell_zero, ptr, refTape[0] == 8'h00);
    end
  endtask

  task automatic test_random;
    logic [2:0] code;
    logic [7:0] arg;
    logic [7:0] inByte;
    for (int n = 0; n < 200; n++) begin
      code   = 3'($urandom_range(0, 7));
      arg    = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 3));
      inByte = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
      exec_op(code, arg, $urandom_range(0, 3), inByte);
    end
  endtask

  task automatic test_memory_image;
    for (int a = 0; a < 256; a++) begin
      nCompared++;
      if (dm[a] !== refTape[a]) begin
        nMismatched++;
        $display("[TB] FAIL mem_image addr=%h: got %h expected %h", a[7:0], dm[a], refTape[a]);
      end
    end
  endtask

  initial begin
    nCompared = 0;
    nMismatched = 0;
    test_reset();
    test_add_sub_chain();
    test_wrap_left();
    test_move_then_add();
    test_out_stall();
    test_in();
    test_reset_mid_in();
    test_random();
    test_memory_image();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
